// File: rtl/if_stage_prefetch_if.sv
// if_stage_prefetch_if: imem request/grant + in-order response bus (master = fetch stage, slave = memory)
interface if_stage_prefetch_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;
  logic            err;
  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/if_stage_prefetch.sv
// if_stage_prefetch: pipelined imem fetch + prefetch queue; ports clk/rst, stall/flush/redirect in, imem bus, registered pc/instr/valid/fault to ID
module if_stage_prefetch #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR    = '0,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                redirect_valid_i,
  input  logic [XLEN-1:0]     redirect_target_i,
  if_stage_prefetch_if.master imem,
  output logic [XLEN-1:0]     pc_out_o,
  output logic [XLEN-1:0]     instr_out_o,
  output logic                valid_out_o,
  output logic                fault_out_o
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = $clog2(FIFO_DEPTH);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] trk_q [MAX_OUTSTANDING];
  logic [XLEN-1:0] trk_d [MAX_OUTSTANDING];
  logic [CW-1:0]   out_q, out_d, drop_q, drop_d, widx;
  logic [XLEN-1:0] qpc_q [FIFO_DEPTH];
  logic [XLEN-1:0] qins_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] qflt_q;
  logic [QW-1:0]   wp_q, rp_q;
  logic [QW:0]     cnt_q;
  logic            issue, rv_ok, keep, push, pop;
  assign imem.req  = !rst && !redirect_valid_i && 32'(out_q) < MAX_OUTSTANDING
                     && 32'(out_q) + 32'(cnt_q) < FIFO_DEPTH;
  assign imem.addr = fetch_pc_q;
  assign issue = imem.req && imem.gnt;
  assign rv_ok = imem.rvalid && out_q != '0;
  assign keep  = rv_ok && drop_q == '0;
  assign push  = keep && !redirect_valid_i;
  assign pop   = !stall_i && !flush_i && !redirect_valid_i && cnt_q != '0;
  // live tracker entries are outstanding minus pending drops; a same-cycle pop shifts the write slot down
  assign widx  = out_q - drop_q - CW'(keep);
  always_comb begin
    out_d      = out_q + CW'(issue) - CW'(rv_ok);
    drop_d     = redirect_valid_i ? out_q - CW'(rv_ok) : drop_q - CW'(rv_ok && drop_q != '0);
    fetch_pc_d = redirect_valid_i ? redirect_target_i & ~XLEN'(3) : fetch_pc_q + (issue ? XLEN'(4) : '0);
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      trk_d[i] = keep ? trk_q[(i + 1) % MAX_OUTSTANDING] : trk_q[i];
      if (issue && CW'(i) == widx) trk_d[i] = fetch_pc_q;
    end
  end
  always_ff @(posedge clk) begin
    trk_q <= trk_d;
    if (rst) begin
      fetch_pc_q <= RESET_VECTOR;
      out_q      <= '0;
      drop_q     <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      if (redirect_valid_i) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push) begin
          qpc_q[wp_q]  <= trk_q[0];
          qins_q[wp_q] <= imem.err ? NOP : imem.rdata;
          qflt_q[wp_q] <= imem.err;
        end
        wp_q  <= wp_q + QW'(push);
        rp_q  <= rp_q + QW'(pop);
        cnt_q <= cnt_q + (QW+1)'(push) - (QW+1)'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst || redirect_valid_i || flush_i) begin
      pc_out_o    <= '0;
      instr_out_o <= NOP;
      valid_out_o <= 1'b0;
      fault_out_o <= 1'b0;
    end else if (!stall_i) begin
      pc_out_o    <= pop ? qpc_q[rp_q] : pc_out_o;
      instr_out_o <= pop ? qins_q[rp_q] : NOP;
      valid_out_o <= pop;
      fault_out_o <= pop && qflt_q[rp_q];
    end
  end
  a_rvalid_credit: assert property (@(posedge clk) disable iff (rst) imem.rvalid |-> out_q != '0);
endmodule

// File: tb/tb_if_stage_prefetch.sv
// tb_if_stage_prefetch: table vectors, directed corner sequences and random traffic against a stream-level model
module tb_if_stage_prefetch;
  localparam int MO = 2;
  localparam int FD = 4;
  localparam logic [31:0] RV  = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0, rd = 1'b0;
  logic [31:0] tgt = '0, pc_o, ins_o;
  logic v_o, f_o;
  if_stage_prefetch_if #(.XLEN(32)) imem();
  if_stage_prefetch #(.XLEN(32), .RESET_VECTOR(RV), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .redirect_valid_i(rd),
    .redirect_target_i(tgt), .imem(imem), .pc_out_o(pc_o), .instr_out_o(ins_o),
    .valid_out_o(v_o), .fault_out_o(f_o));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, valid_cycles = 0;
  logic [31:0] memq[$];
  logic [31:0] exp_pc, nra, mask = '0, err_addr = 32'h1;
  bit rand_err = 0, rand_mem = 0, rv_en = 1;
  logic s_valid, s_fault, s_req;
  logic [31:0] s_pc, s_instr, s_addr;
  typedef struct { logic st; logic fl; logic ev; logic [31:0] epc; } vec_t;
  vec_t tbl[14];
  function automatic bit err_of(input logic [31:0] a);
    return a == err_addr || (rand_err && a[4:2] == 3'd5);
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, act, exp);
    end
  endtask
  // one clock: sample + check against the stream model, drive inputs, play memory, advance model
  task automatic step(input logic st, input logic fl, input logic r, input logic [31:0] t);
    logic g, rv;
    logic [31:0] ra;
    @(negedge clk);
    s_valid = v_o; s_pc = pc_o; s_instr = ins_o; s_fault = f_o;
    if (s_valid) begin
      valid_cycles++;
      chk("model_pc", s_pc, exp_pc);
      chk("model_instr", s_instr, err_of(exp_pc) ? NOP : exp_pc ^ mask);
      chk("model_fault", 32'(s_fault), 32'(err_of(exp_pc)));
    end
    stall = st; flush = fl; rd = r; tgt = t;
    #1;
    s_req = imem.req; s_addr = imem.addr;
    if (r) chk("req_in_redirect", 32'(s_req), 32'h0);
    g  = rand_mem ? ($urandom_range(0, 2) != 0) : 1'b1;
    rv = rv_en && memq.size() > 0 && (rand_mem ? ($urandom_range(0, 1) == 1) : 1'b1);
    ra = rv ? memq[0] : 32'h0;
    imem.gnt = g; imem.rvalid = rv;
    imem.err = rv && err_of(ra);
    imem.rdata = err_of(ra) ? 32'hDEAD_BEEF : ra ^ mask;
    if (s_req && g) chk("req_addr", s_addr, nra);
    @(posedge clk);
    if (rv) void'(memq.pop_front());
    if (s_req && g) begin
      memq.push_back(s_addr);
      nra += 32'd4;
      chk("inflight_limit", 32'(memq.size() > MO), 32'h0);
    end
    if (r) begin
      exp_pc = t & ~32'h3;
      nra = t & ~32'h3;
    end else if (s_valid && (!st || fl)) exp_pc += 32'd4;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; stall = 0; flush = 0; rd = 0; tgt = '0;
    imem.gnt = 0; imem.rvalid = 0; imem.rdata = '0; imem.err = 0;
    memq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(v_o), 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_instr", ins_o, NOP);
    chk("rst_fault", 32'(f_o), 32'h0);
    chk("rst_req", 32'(imem.req), 32'h0);
    rst = 0;
    exp_pc = RV; nra = RV;
  endtask
  task automatic wait_valid(input string n, input int maxc);
    bit got = 0;
    for (int i = 0; i < maxc && !got; i++) begin
      step(0, 0, 0, 0);
      got = s_valid;
    end
    chk(n, 32'(got), 32'h1);
  endtask
  initial begin
    for (int k = 0; k < 14; k++) begin
      tbl[k].st  = 1'b0;
      tbl[k].fl  = (k == 8);
      tbl[k].ev  = (k >= 3 && k != 9);
      tbl[k].epc = RV + 32'(4 * (k <= 8 ? k - 3 : k - 4));
    end
    do_reset();
    for (int k = 0; k < 14; k++) begin
      step(tbl[k].st, tbl[k].fl, 0, 0);
      chk("tbl_valid", 32'(s_valid), 32'(tbl[k].ev));
      if (tbl[k].ev) begin
        chk("tbl_pc", s_pc, tbl[k].epc);
        chk("tbl_instr", s_instr, tbl[k].epc);
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0);
      if (i >= 6) chk("stall_req_off", 32'(s_req), 32'h0);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      chk("release_valid", 32'(s_valid), 32'h1);
      chk("release_pc", s_pc, RV + 32'h28 + 32'(4 * i));
    end
    rv_en = 0;
    step(0, 0, 1, 32'h100);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h203);
    rv_en = 1;
    step(0, 0, 0, 0);
    chk("redir_hold_req", 32'(s_req), 32'h0);
    step(0, 0, 0, 0);
    chk("redir_req", 32'(s_req), 32'h1);
    chk("redir_addr", s_addr, 32'h200);
    wait_valid("redir_valid_timeout", 10);
    chk("redir_first_pc", s_pc, 32'h200);
    rv_en = 0;
    step(0, 0, 1, 32'h300);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rv_en = 1;
    step(0, 0, 1, 32'h400);
    step(0, 0, 0, 0);
    chk("redir_rv_req", 32'(s_req), 32'h1);
    chk("redir_rv_addr", s_addr, 32'h400);
    wait_valid("redir_rv_timeout", 10);
    chk("redir_rv_pc", s_pc, 32'h400);
    err_addr = 32'h40;
    step(0, 0, 1, 32'h40);
    wait_valid("err_timeout", 10);
    chk("err_pc", s_pc, 32'h40);
    chk("err_instr", s_instr, NOP);
    chk("err_fault", 32'(s_fault), 32'h1);
    step(0, 0, 0, 0);
    chk("err_next_valid", 32'(s_valid), 32'h1);
    chk("err_next_pc", s_pc, 32'h44);
    chk("err_next_fault", 32'(s_fault), 32'h0);
    err_addr = 32'h1;
    step(1, 0, 1, 32'h500);
    repeat (6) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("flush_pre_valid", 32'(s_valid), 32'h1);
    chk("flush_pre_pc", s_pc, 32'h500);
    step(0, 0, 0, 0);
    chk("flush_gap", 32'(s_valid), 32'h0);
    step(0, 0, 0, 0);
    chk("flush_next_valid", 32'(s_valid), 32'h1);
    chk("flush_next_pc", s_pc, 32'h504);
    mask = 32'h1234_5678; rand_err = 1; rand_mem = 1; rv_en = 1;
    do_reset();
    valid_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0, $urandom);
    end
    chk("random_activity", 32'(valid_cycles > 200), 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_stage_prefetch.md
Name: if_stage_prefetch

Overview:
Parametrised instruction-fetch stage with a decoupled prefetch queue. It issues pipelined requests to instruction memory using a request/grant and in-order response protocol, with up to MAX_OUTSTANDING requests in flight. Returned instructions are buffered in a FIFO_DEPTH-entry queue and handed to ID through a registered output. It adds a configurable reset vector, redirect with in-flight response squashing, and fetch-fault reporting.

Parameters:
XLEN, 32, data/address width.
RESET_VECTOR, 32'h0000_0000, fetch PC after reset.
FIFO_DEPTH, 4, prefetch queue entries; power of 2, >=2.
MAX_OUTSTANDING, 2, maximum in-flight imem requests; >=1, <=FIFO_DEPTH.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
stall  in  1  ID not accepting; hold the output register.
flush  in  1  clear the output register only.
redirect_valid  in  1  PC redirect (branch, jump or trap).
redirect_target  in  XLEN  new fetch PC; bits [1:0] ignored and treated as 0.
imem_req  out  1  request valid.
imem_addr  out  XLEN  request address, word aligned.
imem_gnt  in  1  request accepted this cycle.
imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant.
imem_rdata  in  XLEN  response instruction.
imem_err  in  1  response bus error; qualified by imem_rvalid.
pc_out  out  XLEN  PC of the instruction presented to ID.
instr_out  out  XLEN  instruction presented to ID.
valid_out  out  1  pc_out/instr_out valid.
fault_out  out  1  fetch fault on this instruction.

Behaviour:
- Reset: fetch_pc=RESET_VECTOR; queue empty; outstanding=0; drop_cnt=0; pc_out=0; instr_out=32'h0000_0013; valid_out=0; fault_out=0; imem_req=0.
- Credit rule: imem_req = !rst & !redirect_valid & (outstanding < MAX_OUTSTANDING) & (outstanding + count < FIFO_DEPTH). Here outstanding includes requests still to be dropped. imem_addr = fetch_pc.
- Issue: on imem_req & imem_gnt, fetch_pc += 4 and the issued PC is pushed into the in-flight PC tracker, a MAX_OUTSTANDING-deep FIFO. outstanding increments on grant and decrements on rvalid; both in the same cycle means no change. fetch_pc wraps modulo 2^XLEN.
- Response: on rvalid, pop the tracker.
  - If drop_cnt>0: decrement drop_cnt and discard the data.
  - Otherwise push {pc, rdata, err} into the queue. When err=1, the stored instr is the NOP and fault=1.
- The credit rule guarantees the queue never overflows. An rvalid with outstanding==0 is ignored (assertion error).
- Output register, when !stall:
  - Queue non-empty: load the head into pc_out/instr_out/fault_out, set valid_out=1, pop the head.
  - Queue empty: valid_out=0, instr_out=NOP, fault_out=0; pc_out holds.
- When stall=1 the output register holds and the queue does not pop.
- Fall-through: a response pushed into an empty queue cannot load the output register in the same cycle. Minimum latency is grant edge -> rvalid -> queue push -> output register, so valid_out rises 1 cycle after the rvalid cycle.
- flush: output register cleared to its reset values. Queue and in-flight requests are unaffected.
- Redirect (highest priority after rst; overrides stall and flush):
  - fetch_pc = {redirect_target[XLEN-1:2], 2'b00}.
  - Queue and PC tracker emptied; output register cleared.
  - drop_cnt = outstanding - (imem_rvalid ? 1 : 0). An rvalid arriving in the redirect cycle is discarded.
  - imem_req=0 in the redirect cycle. The first request to the target can issue the next cycle, subject to credits.
- Back-to-back redirects: each one recomputes drop_cnt from the current outstanding.
- Reset mid-operation clears all counters. The memory is reset concurrently, so no stale responses are expected.

Test Plan:
- RESET_VECTOR=32'h8000_0000, zero-wait memory returning instr=addr: valid_out sequence pc_out=0x80000000, 0x80000004, 0x80000008…; no gaps after fill; instr_out matches.
- stall held 10 cycles, FIFO_DEPTH=4, MAX_OUTSTANDING=2: queue reaches 4 entries and imem_req stays 0. After release, 4 consecutive valid_out with no lost or duplicated PCs.
- Two requests outstanding (0x100, 0x104), then redirect_target=0x203: next request addr=0x200; both late responses discarded; first valid_out has pc_out=0x200.
- redirect_valid in the same cycle as rvalid, with outstanding=2: drop_cnt=1; exactly one further response dropped.
- Response to 0x40 with imem_err=1: pc_out=0x40, instr_out=0x00000013, fault_out=1, valid_out=1. The following instruction has fault_out=0.
- flush with stall=0 and a queue of 3 entries: valid_out=0 for 1 cycle. The next cycle presents the queue head, with no entry lost.
